// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared state encoding, BCD digit limits and seconds helper for the round timer
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam int SEC_UNITS_MAX = 9;
    localparam int SEC_TENS_MAX  = 5;
    localparam int MIN_MAX       = 9;

    function automatic logic [9:0] bcd_to_secs(input logic [3:0] m1, input logic [2:0] s2,
                                               input logic [3:0] s1);
        return 10'(m1) * 10'd60 + 10'(s2) * 10'd10 + 10'(s1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a one-cycle tick every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic at_last,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign at_last = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (enable) begin
                if (at_last) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - round timer FSM and BCD mm:ss countdown; warn blink under TIMER_WARN_BLINK_EN
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ROUND_M1  = 2,
    parameter int ROUND_S2  = 0,
    parameter int ROUND_S1  = 0,
    parameter int WARN_SECS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause_tgl,
    input  logic       abort,
    output logic [3:0] m1,
    output logic [2:0] s2,
    output logic [3:0] s1,
    output logic       sec_tick,
    output logic       time_up,
    output logic       running,
    output logic [1:0] state,
    output logic       warn
);

    localparam int RL_M1_I = (ROUND_M1 > MIN_MAX)       ? MIN_MAX       : ROUND_M1;
    localparam int RL_S2_I = (ROUND_S2 > SEC_TENS_MAX)  ? SEC_TENS_MAX  : ROUND_S2;
    localparam int RL_S1_I = (ROUND_S1 > SEC_UNITS_MAX) ? SEC_UNITS_MAX : ROUND_S1;
    localparam logic [3:0] RL_M1 = 4'(RL_M1_I);
    localparam logic [2:0] RL_S2 = 3'(RL_S2_I);
    localparam logic [3:0] RL_S1 = 4'(RL_S1_I);
    localparam bit RL_ZERO = (RL_M1_I == 0) && (RL_S2_I == 0) && (RL_S1_I == 0);

    if (TICK_DIV < 2 || WARN_SECS < 0) begin : g_bad_config
        $error("game_timer_ctrl: TICK_DIV must be >= 2 and WARN_SECS >= 0");
    end

    timer_state_t st;
    logic         at_last, presc_en, presc_clr, wrap;
    logic [3:0]   nm1, ns1;
    logic [2:0]   ns2;
    logic         n_zero;

    assign state = st;

    // A pause landing on the wrap cycle holds the prescaler so no tick is issued while pausing.
    assign presc_clr = abort || start;
    assign presc_en  = (st == ST_RUN) && !presc_clr && !(pause_tgl && at_last);
    assign wrap      = presc_en && at_last;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (presc_en),
        .clear   (presc_clr),
        .at_last (at_last),
        .tick    (sec_tick)
    );

    always_comb begin
        nm1 = m1;
        ns2 = s2;
        ns1 = s1;
        if (s1 != 4'd0) begin
            ns1 = s1 - 4'd1;
        end else if (s2 != 3'd0) begin
            ns1 = 4'(SEC_UNITS_MAX);
            ns2 = s2 - 3'd1;
        end else begin
            ns1 = 4'(SEC_UNITS_MAX);
            ns2 = 3'(SEC_TENS_MAX);
            nm1 = m1 - 4'd1;
        end
        n_zero = (nm1 == 4'd0) && (ns2 == 3'd0) && (ns1 == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            m1      <= 4'd0;
            s2      <= 3'd0;
            s1      <= 4'd0;
            time_up <= 1'b0;
            running <= 1'b0;
        end else begin
            time_up <= 1'b0;
            if (abort) begin
                st      <= ST_IDLE;
                m1      <= 4'd0;
                s2      <= 3'd0;
                s1      <= 4'd0;
                running <= 1'b0;
            end else if (start) begin
                m1 <= RL_M1;
                s2 <= RL_S2;
                s1 <= RL_S1;
                if (RL_ZERO) begin
                    st      <= ST_EXPIRED;
                    time_up <= 1'b1;
                    running <= 1'b0;
                end else begin
                    st      <= ST_RUN;
                    running <= 1'b1;
                end
            end else if (pause_tgl && st == ST_RUN) begin
                st      <= ST_PAUSE;
                running <= 1'b0;
            end else if (pause_tgl && st == ST_PAUSE) begin
                st      <= ST_RUN;
                running <= 1'b1;
            end else if (wrap) begin
                m1 <= nm1;
                s2 <= ns2;
                s1 <= ns1;
                if (n_zero) begin
                    st      <= ST_EXPIRED;
                    time_up <= 1'b1;
                    running <= 1'b0;
                end
            end
        end
    end

`ifdef TIMER_WARN_BLINK_EN
    localparam int WARN_I = (WARN_SECS > 599) ? 599 : WARN_SECS;
    localparam logic [9:0] WARN_LIM = 10'(WARN_I);
    localparam logic [9:0] RL_SECS  = 10'(RL_M1_I * 60 + RL_S2_I * 10 + RL_S1_I);

    logic [9:0] cur_secs, nxt_secs;
    assign cur_secs = bcd_to_secs(m1, s2, s1);
    assign nxt_secs = bcd_to_secs(nm1, ns2, ns1);

    // Blink phase starts at 1 on the tick that crosses the threshold, then toggles per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn <= 1'b0;
        end else if (abort) begin
            warn <= 1'b0;
        end else if (start) begin
            warn <= !RL_ZERO && (RL_SECS <= WARN_LIM);
        end else if (pause_tgl && (st == ST_RUN || st == ST_PAUSE)) begin
            warn <= (cur_secs <= WARN_LIM);
        end else if (wrap) begin
            if (n_zero)
                warn <= 1'b0;
            else if (nxt_secs <= WARN_LIM)
                warn <= (cur_secs > WARN_LIM) ? 1'b1 : ~warn;
            else
                warn <= 1'b0;
        end
    end
`else
    assign warn = 1'b0;
`endif

endmodule
